// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank.
// NUM_REGS registers of DATA_WIDTH bits, byte-addressed, with WSTRB byte
// enables, independent AW/W acceptance and one outstanding write/read.
// Optional build macro AXIL_ADDR_ERR_EN: out-of-range accesses answer
// SLVERR instead of OKAY (handshake timing is the same either way).
module axi4lite_regbank #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_ADDR_ERR_EN
  localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

  logic                                 r_live;
  logic                                 r_aw_full, r_w_full;
  logic [ADDR_WIDTH-1:0]                r_aw_addr;
  logic [DATA_WIDTH-1:0]                r_w_data;
  logic [STRB_W-1:0]                    r_w_strb;
  logic                                 r_bvalid, r_rvalid;
  logic [1:0]                           r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0]                r_rdata;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  r_regs;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_waddr, w_widx, w_ridx;
  logic [DATA_WIDTH-1:0] w_wdata, w_rd_val;
  logic [STRB_W-1:0]     w_wstrb;
  logic                  w_wr_ok, w_rd_ok;

  // A slot only accepts while empty and no write response is outstanding.
  assign s_awready = r_live & ~r_aw_full & ~r_bvalid;
  assign s_wready  = r_live & ~r_w_full  & ~r_bvalid;
  assign s_arready = r_live & ~r_rvalid;

  assign w_aw_hs  = s_awvalid & s_awready;
  assign w_w_hs   = s_wvalid  & s_wready;
  assign w_ar_hs  = s_arvalid & s_arready;
  // Commit as soon as address and data are both on hand, held or live.
  assign w_commit = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);

  assign w_waddr = r_aw_full ? r_aw_addr : s_awaddr;
  assign w_wdata = r_w_full  ? r_w_data  : s_wdata;
  assign w_wstrb = r_w_full  ? r_w_strb  : s_wstrb;
  assign w_widx  = w_waddr  >> ADDR_LSB;
  assign w_ridx  = s_araddr >> ADDR_LSB;
  assign w_wr_ok = (w_widx <= LAST_IDX);
  assign w_rd_ok = (w_ridx <= LAST_IDX);

  assign s_bvalid = r_bvalid;
  assign s_bresp  = r_bresp;
  assign s_rvalid = r_rvalid;
  assign s_rdata  = r_rdata;
  assign s_rresp  = r_rresp;
  assign reg_out  = r_regs;

  // Read mux; no index match leaves zero for out-of-range reads.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_ridx == ADDR_WIDTH'(i)) w_rd_val = r_regs[i];
  end

  // Ready gating: readies stay low until the first edge out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // AW/W holding slots; both empty on the commit edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= s_awaddr;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= s_wdata;
        r_w_strb <= s_wstrb;
      end
    end
  end

  // Register array: byte-masked write on commit to an in-range index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else if (w_commit && w_wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_widx == ADDR_WIDTH'(i))
          for (int b = 0; b < STRB_W; b++)
            if (w_wstrb[b]) r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
    end
  end

  // Write response: raised on commit, held until BREADY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_OOR;
    end else if (r_bvalid && s_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read response: registered on AR handshake (pre-commit register value),
  // held until RREADY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_ok ? w_rd_val : '0;
      r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_OOR;
    end else if (r_rvalid && s_rready) begin
      r_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi4lite_regbank.sv
// Scoreboard bench for axi4lite_regbank (ADDR_WIDTH=5 so 0x10 is out of range).
// Builds with or without AXIL_ADDR_ERR_EN; expected OOR response follows it.
module tb_axi4lite_regbank;
  localparam int AW = 5, DW = 32, NR = 4;
`ifdef AXIL_ADDR_ERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
  logic [DW-1:0] s_wdata = '0;
  logic [3:0] s_wstrb = '0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic [DW-1:0] s_rdata;
  logic [NR*DW-1:0] reg_out;

  int checks = 0, errors = 0;
  logic [31:0] mdl [NR];
  logic [1:0]  qb [$];
  logic [33:0] qr [$];

  axi4lite_regbank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg_out(reg_out));

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [127:0] mdl_flat();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Push expected B, update model, then run AW/W; lead>0: W leads, lead<0: AW leads.
  task automatic issue_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    int idx, aw_start, w_start;
    bit aw_done, w_done;
    logic aw_hs, w_hs;
    idx = int'(a) >> 2;
    if (idx < NR) begin qb.push_back(2'b00); mdl[idx] = merge(mdl[idx], d, s); end
    else qb.push_back(OOR);
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0;
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    for (int k = 0; k < 60 && !(aw_done && w_done); k++) begin
      s_awvalid = !aw_done && (k >= aw_start);
      s_wvalid  = !w_done  && (k >= w_start);
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
    end
    s_awvalid = 0; s_wvalid = 0;
    if (!(aw_done && w_done)) begin
      checks++; errors++;
      $display("FAIL write_handshake addr=%h aw_done=%0d w_done=%0d", a, aw_done, w_done);
    end
  endtask

  task automatic issue_read(input logic [AW-1:0] a);
    int idx;
    bit done;
    idx = int'(a) >> 2;
    if (idx < NR) qr.push_back({2'b00, mdl[idx]});
    else          qr.push_back({OOR, 32'h0});
    s_araddr = a; s_arvalid = 1; done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      done = s_arready;
      tick();
    end
    s_arvalid = 0;
    if (!done) begin checks++; errors++; $display("FAIL read_handshake addr=%h", a); end
  endtask

  task automatic wait_b(output logic [1:0] resp);
    resp = 2'bxx; s_bready = 1;
    for (int k = 0; k < 50; k++) begin
      if (s_bvalid) begin resp = s_bresp; tick(); s_bready = 0; return; end
      tick();
    end
    s_bready = 0; checks++; errors++;
    $display("FAIL bvalid_timeout");
  endtask

  task automatic wait_r(output logic [33:0] v);
    v = 'x; s_rready = 1;
    for (int k = 0; k < 50; k++) begin
      if (s_rvalid) begin v = {s_rresp, s_rdata}; tick(); s_rready = 0; return; end
      tick();
    end
    s_rready = 0; checks++; errors++;
    $display("FAIL rvalid_timeout");
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    rst_n = 0;
    repeat (3) tick();
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0 || reg_out !== '0 ||
        s_rdata !== '0 || s_bresp !== 2'b00 || s_rresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_state rdy=%b%b%b bv=%b rv=%b reg_out=%h req all 0",
               s_awready, s_wready, s_arready, s_bvalid, s_rvalid, reg_out);
    end
    rst_n = 1;
    tick();
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_reset got=%b%b%b req=111", s_awready, s_wready, s_arready);
    end
  endtask

  task automatic test_basic();
    logic [1:0] gb, eb;
    logic [33:0] gr, er;
    qb.push_back(2'b00); mdl[2] = 32'hDEADBEEF;
    s_awaddr = 5'h08; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if (s_bvalid !== 1'b1 || reg_out[95:64] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_latency bvalid=%b reg2=%h req 1/deadbeef", s_bvalid, reg_out[95:64]);
    end
    wait_b(gb); eb = qb.pop_front(); checks++;
    if (gb !== eb) begin errors++; $display("FAIL basic_bresp got=%b exp=%b", gb, eb); end
    checks++;
    if (s_bvalid !== 1'b0) begin errors++; $display("FAIL basic_bvalid_drop got=%b exp=0", s_bvalid); end
    issue_read(5'h08); wait_r(gr); er = qr.pop_front(); checks++;
    if (gr !== er) begin errors++; $display("FAIL basic_read got=%h exp=%h", gr, er); end
  endtask

  task automatic test_order();
    logic [1:0] gb, eb;
    s_wdata = 32'h11223344; s_wstrb = 4'hF; s_wvalid = 1;
    tick();
    s_wvalid = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (s_awready !== 1'b1 || s_bvalid !== 1'b0 || reg_out[63:32] !== mdl[1]) begin
        errors++; $display("FAIL w_first_hold cyc=%0d awready=%b bvalid=%b reg1=%h exp 1/0/%h",
                           k, s_awready, s_bvalid, reg_out[63:32], mdl[1]);
      end
      tick();
    end
    qb.push_back(2'b00); mdl[1] = 32'h11223344;
    s_awaddr = 5'h04; s_awvalid = 1;
    tick();
    s_awvalid = 0;
    checks++;
    if (s_bvalid !== 1'b1 || reg_out !== mdl_flat()) begin
      errors++; $display("FAIL w_first_commit bvalid=%b reg_out=%h exp=%h", s_bvalid, reg_out, mdl_flat());
    end
    wait_b(gb); eb = qb.pop_front(); checks++;
    if (gb !== eb) begin errors++; $display("FAIL w_first_bresp got=%b exp=%b", gb, eb); end
    // clear, then AW leads by 3 cycles
    issue_write(5'h04, 32'h0, 4'hF, 0); wait_b(gb); void'(qb.pop_front());
    issue_write(5'h04, 32'h11223344, 4'hF, -3); wait_b(gb); eb = qb.pop_front(); checks++;
    if (gb !== eb || reg_out[63:32] !== 32'h11223344) begin
      errors++; $display("FAIL aw_first got resp=%b reg1=%h exp resp=%b reg1=11223344", gb, reg_out[63:32], eb);
    end
  endtask

  task automatic test_wstrb();
    logic [1:0] gb, eb;
    issue_write(5'h04, 32'hAABBCCDD, 4'b0101, 0); wait_b(gb); eb = qb.pop_front(); checks++;
    if (gb !== eb || reg_out[63:32] !== 32'h11BB33DD || reg_out !== mdl_flat()) begin
      errors++; $display("FAIL wstrb_0101 resp=%b reg1=%h exp resp=%b reg1=11bb33dd", gb, reg_out[63:32], eb);
    end
    issue_write(5'h04, 32'hFFFFFFFF, 4'b0000, 0); wait_b(gb); eb = qb.pop_front(); checks++;
    if (gb !== eb || reg_out[63:32] !== 32'h11BB33DD) begin
      errors++; $display("FAIL wstrb_0000 resp=%b reg1=%h exp resp=%b reg1=11bb33dd", gb, reg_out[63:32], eb);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] gb, eb, b0;
    logic [33:0] gr, er, r0;
    issue_write(5'h08, 32'h0F0F0F0F, 4'hF, 0);
    b0 = s_bresp;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (s_bvalid !== 1'b1 || s_bresp !== b0 || s_awready !== 1'b0 || s_wready !== 1'b0) begin
        errors++; $display("FAIL b_stall cyc=%0d bvalid=%b bresp=%b awr=%b wr=%b exp 1/%b/0/0",
                           k, s_bvalid, s_bresp, s_awready, s_wready, b0);
      end
      tick();
    end
    wait_b(gb); eb = qb.pop_front(); checks++;
    if (gb !== eb) begin errors++; $display("FAIL b_stall_resp got=%b exp=%b", gb, eb); end
    issue_read(5'h08);
    r0 = {s_rresp, s_rdata};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (s_rvalid !== 1'b1 || {s_rresp, s_rdata} !== r0 || s_arready !== 1'b0) begin
        errors++; $display("FAIL r_stall cyc=%0d rvalid=%b r=%h arready=%b exp 1/%h/0",
                           k, s_rvalid, {s_rresp, s_rdata}, s_arready, r0);
      end
      tick();
    end
    wait_r(gr); er = qr.pop_front(); checks++;
    if (gr !== er) begin errors++; $display("FAIL r_stall_data got=%h exp=%h", gr, er); end
  endtask

  task automatic test_same_edge();
    logic [1:0] gb, eb;
    logic [33:0] gr, er;
    qr.push_back({2'b00, mdl[3]});
    qb.push_back(2'b00); mdl[3] = 32'h5;
    s_awaddr = 5'h0C; s_wdata = 32'h5; s_wstrb = 4'hF; s_araddr = 5'h0C;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    wait_r(gr); er = qr.pop_front(); checks++;
    if (gr !== er) begin errors++; $display("FAIL same_edge_old got=%h exp=%h", gr, er); end
    wait_b(gb); eb = qb.pop_front(); checks++;
    if (gb !== eb) begin errors++; $display("FAIL same_edge_bresp got=%b exp=%b", gb, eb); end
    issue_read(5'h0F); wait_r(gr); er = qr.pop_front(); checks++;
    if (gr !== er) begin errors++; $display("FAIL same_edge_new got=%h exp=%h", gr, er); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] gb, eb;
    logic [33:0] gr, er;
    logic [127:0] snap;
    snap = reg_out;
    issue_write(5'h10, 32'hFFFFFFFF, 4'hF, 0); wait_b(gb); eb = qb.pop_front(); checks++;
    if (gb !== eb || reg_out !== snap) begin
      errors++; $display("FAIL oor_write resp=%b reg_out=%h exp resp=%b reg_out=%h", gb, reg_out, eb, snap);
    end
    issue_read(5'h10); wait_r(gr); er = qr.pop_front(); checks++;
    if (gr !== er) begin errors++; $display("FAIL oor_read got=%h exp=%h", gr, er); end
    issue_read(5'h1F); wait_r(gr); er = qr.pop_front(); checks++;
    if (gr !== er) begin errors++; $display("FAIL oor_read_top got=%h exp=%h", gr, er); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] gb;
    issue_write(5'h00, 32'hCAFEF00D, 4'hF, 0);
    issue_read(5'h00);
    rst_n = 0;
    tick();
    checks++;
    if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0 || reg_out !== '0) begin
      errors++; $display("FAIL reset_mid bvalid=%b rvalid=%b reg_out=%h req 0/0/0", s_bvalid, s_rvalid, reg_out);
    end
    rst_n = 1; qb.delete(); qr.delete();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    tick();
    // a W held in its slot must be discarded by reset
    s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1;
    tick();
    s_wvalid = 0; rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    s_awaddr = 5'h04; s_awvalid = 1;
    tick();
    s_awvalid = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (s_bvalid !== 1'b0 || reg_out !== '0) begin
        errors++; $display("FAIL reset_slot cyc=%0d bvalid=%b reg_out=%h req 0/0", k, s_bvalid, reg_out);
      end
      tick();
    end
    s_wdata = 32'h9; s_wvalid = 1;
    tick();
    s_wvalid = 0; mdl[1] = 32'h9;
    checks++;
    if (s_bvalid !== 1'b1 || reg_out !== mdl_flat()) begin
      errors++; $display("FAIL reset_slot_commit bvalid=%b reg_out=%h exp=%h", s_bvalid, reg_out, mdl_flat());
    end
    wait_b(gb); checks++;
    if (gb !== 2'b00) begin errors++; $display("FAIL reset_slot_bresp got=%b exp=00", gb); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_wstrb();
    test_backpressure();
    test_same_edge();
    test_out_of_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi4lite_regbank.md
Name: axi4lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 2-bit-address / 8-bit-data AXI4-Lite slave in the tt_um top.
- Adds:
  - independent AW/W channel acceptance in either order
  - WSTRB byte enables
  - configurable register count
  - full BREADY/RREADY backpressure
  - error responses for out-of-range addresses
- Contents are exported as a flat bus so fabric logic can observe the registers directly.

Parameters:
- ADDR_WIDTH, 4, byte-address width of AWADDR/ARADDR.
- DATA_WIDTH, 32, data width; must be 8, 16, 32 or 64.
- NUM_REGS, 4, number of implemented registers; must be >= 1 and <= 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_awaddr  in  ADDR_WIDTH  write address (byte).
- s_awvalid  in  1  write address valid.
- s_awready  out  1  write address ready.
- s_wdata  in  DATA_WIDTH  write data.
- s_wstrb  in  DATA_WIDTH/8  byte enables.
- s_wvalid  in  1  write data valid.
- s_wready  out  1  write data ready.
- s_bresp  out  2  write response (00 OKAY, 10 SLVERR).
- s_bvalid  out  1  write response valid.
- s_bready  in  1  write response ready.
- s_araddr  in  ADDR_WIDTH  read address (byte).
- s_arvalid  in  1  read address valid.
- s_arready  out  1  read address ready.
- s_rdata  out  DATA_WIDTH  read data.
- s_rresp  out  2  read response.
- s_rvalid  out  1  read data valid.
- s_rready  in  1  read data ready.
- reg_out  out  NUM_REGS*DATA_WIDTH  flat register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
Reset:
- Synchronous, sampled at clk edge while rst_n=0.
- All registers, reg_out, s_bvalid, s_rvalid, s_rdata, s_bresp, s_rresp = 0.
- s_awready, s_wready, s_arready = 0 during reset; high on the first cycle after rst_n=1.

Addressing:
- Register index = addr >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
- Index >= NUM_REGS is out of range.

Write path:
- Two independent holding slots, AW and W.
- s_awready = AW slot empty and s_bvalid=0; s_wready = W slot empty and s_bvalid=0.
- Either handshake may precede the other by any number of cycles; the earlier one is held in its slot.
- Commit edge = the edge on which both address and data are available (held or handshaking that edge). On that edge:
  - each byte b with wstrb[b]=1 is written; bytes with wstrb[b]=0 are unchanged
  - both slots clear
  - s_bvalid rises
- Latency: AW and W in the same cycle -> s_bvalid high the next cycle; the write is visible on reg_out that same next cycle.
- s_bvalid and s_bresp hold until s_bready=1; s_bvalid drops on the following edge.
- No new AW/W is accepted while s_bvalid=1: max one outstanding write.
- wstrb=0 is a legal no-op write returning OKAY.

Read path:
- s_arready = !s_rvalid.
- On AR handshake: s_rdata and s_rresp are registered and s_rvalid=1 on the next cycle.
- All three hold stable until s_rready=1; s_rvalid clears on that edge.
- s_arready is high again the cycle after the clear: back-to-back reads every 2 cycles.

Simultaneous events:
- Read and write channels are independent.
- AR handshake on the same edge as a write commit to the same register returns the OLD value; the next read returns the new value.

Reset mid-operation:
- Held slots, pending B/R responses and register contents are all discarded and cleared.
- Reset is not a bus error.

Optional Feature:
- Macro: AXIL_ADDR_ERR_EN.
- Defined: out-of-range write -> no register change, s_bresp=10 (SLVERR); out-of-range read -> s_rdata=0, s_rresp=10.
- Undefined: out-of-range writes are silently dropped with OKAY; reads return 0 with OKAY.
- Handshake timing is identical in both builds.

Test Plan:
- Defaults; AW=0x8 and W=0xDEADBEEF, wstrb=0xF in the same cycle; bready=1 -> bvalid high 1 cycle later, bresp=00, reg_out[95:64]=0xDEADBEEF; AR 0x8 returns 0xDEADBEEF, OKAY.
- W first (0x11223344), AW=0x4 issued 3 cycles later -> awready high until the AW handshake, commit only after it, reg1=0x11223344; repeat with AW first -> same result.
- Reg1=0x11223344; write 0xAABBCCDD with wstrb=0101 -> reg1=0x11BB33DD; wstrb=0000 -> unchanged, OKAY.
- bready held low 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout; rready low 4 cycles on a read -> rdata stable, arready=0.
- AR 0xC on the commit edge of a write 0x5 to 0xC (reg previously 0) -> rdata=0; next read -> 5.
- AW 0x10 with NUM_REGS=4 -> with AXIL_ADDR_ERR_EN: bresp=10, read rresp=10, rdata=0, regs unchanged; without: bresp=00, rresp=00, rdata=0. Mid-transaction rst_n=0 for 1 cycle -> all regs 0, bvalid=rvalid=0.
